note_voice_alloc: RTL
=====================

# note_voice_alloc

Voice allocator and event sequencer on the MIDI side of the synth engine. It accepts note-on and note-off events over a valid/ready handshake and assigns each one to a voice slot. It keeps the per-voice key table and the keys_on vector, and drives the note_on / cur_key_adr / cur_key_val / cur_vel_on / keys_on bundle consumed by the voice-engine sync stage. After every update it holds the bundle stable for a programmable number of cycles, so the slower sample-rate domain can capture it safely.

## Interface
- VOICES, 8, number of voice slots
- V_WIDTH, 3, voice index width; must satisfy 2**V_WIDTH == VOICES
- HOLD_CYCLES, 64, cycles the output bundle is held after an update; minimum 1
- sys_clk  in  1  system clock, rising edge
- reset_reg_N  in  1  reset, asynchronous, active-low
- ev_valid  in  1  event present; requester holds it and the data stable until accepted
- ev_ready  out  1  allocator can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  8  MIDI key number
- ev_vel  in  8  MIDI velocity
- note_on  out  1  level; high while a note-on update is presented
- cur_key_adr  out  V_WIDTH  voice slot of the last update
- cur_key_val  out  8  key of the last update
- cur_vel_on  out  8  velocity of the last note-on
- keys_on  out  VOICES  per-voice gate
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: ev_ready=1. An event is accepted when ev_valid&ev_ready; the accepted event goes to SCAN.
  - SCAN: VOICES cycles, one slot per cycle.
  - ISSUE: 1 cycle.
  - HOLD: HOLD_CYCLES cycles, then back to IDLE.
- Accept: latch ev_on, ev_key and ev_vel. A note-on with ev_vel==0 is treated as a note-off.
- SCAN checks slot i in cycle i, in ascending order, and records:
  - match: lowest i with keys_on[i]=1 and key_tab[i]==key
  - free: lowest i with keys_on[i]=0
- ISSUE for a note-on:
  - Target is chosen by priority: match (retrigger), then free, then steal_ptr.
  - When steal_ptr is used, it advances by 1 mod VOICES.
  - Writes: key_tab[target]=key, keys_on[target]=1, cur_key_adr=target, cur_key_val=key, cur_vel_on=vel, note_on=1.
- ISSUE for a note-off with a match:
  - Writes: keys_on[target]=0, cur_key_adr=target, cur_key_val=key, note_on=0.
  - cur_vel_on is unchanged.
- ISSUE for a note-off with no match: no output or table change; the next state is IDLE and HOLD is skipped.
- HOLD: all outputs are frozen. note_on clears to 0 on the transition HOLD→IDLE.
- key_tab is internal only. It holds VOICES × 8-bit entries and is not reset; validity is given by keys_on.

## Timing
- Reset values:
  - state=IDLE, so ev_ready=1 and busy=0
  - note_on=0, cur_key_adr=0, cur_key_val=0, cur_vel_on=0, keys_on=0, steal_ptr=0
- ev_ready and busy are decoded combinationally from state.
- Latency, with acceptance at edge T:
  - SCAN runs on edges T+1 .. T+VOICES.
  - ISSUE outputs are registered at edge T+VOICES+1.
  - ev_ready returns high after edge T+VOICES+1+HOLD_CYCLES.
- Throughput: one event per VOICES+1+HOLD_CYCLES cycles. An unmatched note-off takes VOICES+1 cycles.
- If several slots hold the same key, only the lowest-index slot is matched.
- Boundaries:
  - All voices busy with no match: steal at steal_ptr. After VOICES consecutive steals, steal_ptr wraps back to 0.
  - Slot VOICES-1 is the last one scanned; match and free are resolved at the ISSUE edge.
  - ev_valid while ev_ready=0 has no effect. The event waits and no event is ever dropped.
  - Reset asserted mid-SCAN or mid-HOLD: immediate return to reset values. The in-flight event is discarded.

## Structure
- Shared synth header: state encodings (IDLE/SCAN/ISSUE/HOLD), the HOLD counter width as clog2(HOLD_CYCLES+1), and the VOICES/V_WIDTH defaults used across the engine.
- One natural sub-module, voice_match_scan:
  - holds the scan index and the match/free trackers
  - clears them on start and reports match_vld, match_idx, free_vld, free_idx
- The FSM, tables and output registers stay in the top module.

## Test plan
Simulation parameters: VOICES=8, HOLD_CYCLES=4.
- Note-on key 60 vel 100 out of reset:
  - cur_key_adr=0, cur_key_val=60, cur_vel_on=100, keys_on=8'h01, note_on=1, at 9 cycles after acceptance.
  - ev_ready returns high 4 cycles later, and note_on drops to 0 at that point.
- Note-ons for keys 60..67 fill slots 0..7 and keys_on=8'hFF. Then:
  - key 70 steals slot 0
  - key 71 steals slot 1
  - steal_ptr=2 afterwards
- Retrigger and velocity-zero release, starting with key 62 in slot 2:
  - A note-on for key 62 with vel 50 reuses slot 2 and sets cur_vel_on=50; keys_on is unchanged.
  - A note-on for key 62 with vel 0 clears keys_on[2] and sets note_on=0.
- Note-off for key 99 when no slot holds it:
  - no output change
  - ev_ready returns high 9 cycles after acceptance, with no HOLD
- Back-to-back events:
  - ev_valid is held high with the second event during HOLD.
  - The second event is accepted on the first cycle ev_ready=1; ordering and data are preserved.
- Reset asserted mid-SCAN:
  - all outputs are zero, ev_ready=1, and the event is discarded
  - a fresh note-on then lands in slot 0

Source files
------------

// File: rtl/note_voice_alloc_pkg.sv
// Shared synth-engine definitions for the MIDI-side voice allocator.
//   - engine-wide VOICES / V_WIDTH defaults and MIDI field widths
//   - allocator FSM state encoding
//   - note event payload and HOLD counter width helper
package note_voice_alloc_pkg;

    localparam int unsigned VOICES_DEF  = 8;
    localparam int unsigned V_WIDTH_DEF = 3;
    localparam int unsigned KEY_W       = 8;
    localparam int unsigned VEL_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Accepted event; 'on' already folds velocity-zero note-ons into note-offs.
    typedef struct packed {
        logic             on;
        logic [KEY_W-1:0] key;
        logic [VEL_W-1:0] vel;
    } note_ev_t;

    // HOLD counter must be able to count up to HOLD_CYCLES.
    function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/voice_match_scan.sv
// Sequential slot scanner: examines one voice slot per enabled cycle in
// ascending order and records the lowest matching slot and the lowest free slot.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i           clear index and trackers (event accepted)
//   en_i              scan the slot at the current index this cycle
//   key_i             key being searched for
//   keys_on_i         per-voice gate vector
//   key_tab_i         per-voice key table
//   scan_last_c_o     current cycle scans the final slot (combinational)
//   match_vld_o/idx_o lowest active slot holding key_i
//   free_vld_o/idx_o  lowest inactive slot
module voice_match_scan
    import note_voice_alloc_pkg::*;
#(
    parameter int unsigned VOICES  = VOICES_DEF,
    parameter int unsigned V_WIDTH = V_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          en_i,
    input  logic [KEY_W-1:0]              key_i,
    input  logic [VOICES-1:0]             keys_on_i,
    input  logic [VOICES-1:0][KEY_W-1:0]  key_tab_i,
    output logic                          scan_last_c_o,
    output logic                          match_vld_o,
    output logic [V_WIDTH-1:0]            match_idx_o,
    output logic                          free_vld_o,
    output logic [V_WIDTH-1:0]            free_idx_o
);

    logic [V_WIDTH-1:0] idx_q, idx_d;
    logic               match_vld_q, match_vld_d;
    logic [V_WIDTH-1:0] match_idx_q, match_idx_d;
    logic               free_vld_q, free_vld_d;
    logic [V_WIDTH-1:0] free_idx_q, free_idx_d;

    // Tracker update: first hit wins, so later slots never overwrite a result.
    always_comb begin
        idx_d       = idx_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        if (start_i) begin
            idx_d       = '0;
            match_vld_d = 1'b0;
            match_idx_d = '0;
            free_vld_d  = 1'b0;
            free_idx_d  = '0;
        end else if (en_i) begin
            if (!match_vld_q && keys_on_i[idx_q] && (key_tab_i[idx_q] == key_i)) begin
                match_vld_d = 1'b1;
                match_idx_d = idx_q;
            end
            if (!free_vld_q && !keys_on_i[idx_q]) begin
                free_vld_d = 1'b1;
                free_idx_d = idx_q;
            end
            idx_d = idx_q + V_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
        end
    end

    assign scan_last_c_o = en_i && (idx_q == V_WIDTH'(VOICES - 1));
    assign match_vld_o   = match_vld_q;
    assign match_idx_o   = match_idx_q;
    assign free_vld_o    = free_vld_q;
    assign free_idx_o    = free_idx_q;

endmodule

// File: rtl/note_voice_alloc.sv
// Voice allocator / event sequencer. Accepts note-on/off events over
// valid/ready, assigns them to voice slots, and presents a held output bundle
// to the voice-engine sync stage.
// Ports:
//   sys_clk, reset_reg_N          clock, async active-low reset
//   ev_valid/ev_ready             event handshake
//   ev_on, ev_key, ev_vel         event payload
//   note_on                       high while a note-on update is presented
//   cur_key_adr/val, cur_vel_on   slot, key and velocity of the last update
//   keys_on                       per-voice gate
//   busy                          allocator not idle
module note_voice_alloc
    import note_voice_alloc_pkg::*;
#(
    parameter int unsigned VOICES      = VOICES_DEF,
    parameter int unsigned V_WIDTH     = V_WIDTH_DEF,
    parameter int unsigned HOLD_CYCLES = 64
) (
    input  logic               sys_clk,
    input  logic               reset_reg_N,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [KEY_W-1:0]   ev_key,
    input  logic [VEL_W-1:0]   ev_vel,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [KEY_W-1:0]   cur_key_val,
    output logic [VEL_W-1:0]   cur_vel_on,
    output logic [VOICES-1:0]  keys_on,
    output logic               busy
);

    localparam int unsigned HCW = hold_cnt_w(HOLD_CYCLES);

    state_e                         state_q, state_d;
    note_ev_t                       ev_q;
    logic [V_WIDTH-1:0]             steal_q;
    logic [HCW-1:0]                 hold_cnt_q;
    logic [VOICES-1:0][KEY_W-1:0]   key_tab_q;

    logic               note_on_q;
    logic [V_WIDTH-1:0] cur_key_adr_q;
    logic [KEY_W-1:0]   cur_key_val_q;
    logic [VEL_W-1:0]   cur_vel_on_q;
    logic [VOICES-1:0]  keys_on_q;

    logic               scan_last_c;
    logic               match_vld, free_vld;
    logic [V_WIDTH-1:0] match_idx, free_idx;

    logic               accept_c, scan_en_c, hold_last_c;
    logic               issue_on_c, issue_off_c, use_steal_c;
    logic [V_WIDTH-1:0] target_c;

    voice_match_scan #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH)
    ) u_scan (
        .clk           (sys_clk),
        .rst_n         (reset_reg_N),
        .start_i       (accept_c),
        .en_i          (scan_en_c),
        .key_i         (ev_q.key),
        .keys_on_i     (keys_on_q),
        .key_tab_i     (key_tab_q),
        .scan_last_c_o (scan_last_c),
        .match_vld_o   (match_vld),
        .match_idx_o   (match_idx),
        .free_vld_o    (free_vld),
        .free_idx_o    (free_idx)
    );

    // State register
    always_ff @(posedge sys_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic; an unmatched note-off skips HOLD entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ev_valid)    state_d = ST_SCAN;
            ST_SCAN:  if (scan_last_c) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (!ev_q.on && !match_vld) ? ST_IDLE : ST_HOLD;
            ST_HOLD:  if (hold_last_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM decodes and ISSUE target selection: match, then free, then steal.
    always_comb begin
        ev_ready    = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        accept_c    = ev_ready && ev_valid;
        scan_en_c   = (state_q == ST_SCAN);
        hold_last_c = (state_q == ST_HOLD) && (hold_cnt_q == HCW'(HOLD_CYCLES - 1));
        issue_on_c  = (state_q == ST_ISSUE) && ev_q.on;
        issue_off_c = (state_q == ST_ISSUE) && !ev_q.on && match_vld;
        use_steal_c = issue_on_c && !match_vld && !free_vld;
        target_c    = match_vld ? match_idx : (free_vld ? free_idx : steal_q);
    end

    // Event latch, steal pointer, hold counter and output bundle.
    always_ff @(posedge sys_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            ev_q          <= '0;
            steal_q       <= '0;
            hold_cnt_q    <= '0;
            note_on_q     <= 1'b0;
            cur_key_adr_q <= '0;
            cur_key_val_q <= '0;
            cur_vel_on_q  <= '0;
            keys_on_q     <= '0;
        end else begin
            if (accept_c) begin
                ev_q.on  <= ev_on && (ev_vel != '0);
                ev_q.key <= ev_key;
                ev_q.vel <= ev_vel;
            end
            if (state_q == ST_ISSUE)     hold_cnt_q <= '0;
            else if (state_q == ST_HOLD) hold_cnt_q <= hold_cnt_q + HCW'(1);
            if (use_steal_c) steal_q <= steal_q + V_WIDTH'(1);
            if (issue_on_c) begin
                keys_on_q[target_c] <= 1'b1;
                cur_key_adr_q       <= target_c;
                cur_key_val_q       <= ev_q.key;
                cur_vel_on_q        <= ev_q.vel;
                note_on_q           <= 1'b1;
            end else if (issue_off_c) begin
                keys_on_q[target_c] <= 1'b0;
                cur_key_adr_q       <= target_c;
                cur_key_val_q       <= ev_q.key;
                note_on_q           <= 1'b0;
            end else if (hold_last_c) begin
                note_on_q <= 1'b0;
            end
        end
    end

    // Key table has no reset; keys_on qualifies every entry.
    always_ff @(posedge sys_clk) begin
        if (issue_on_c) key_tab_q[target_c] <= ev_q.key;
    end

    assign note_on     = note_on_q;
    assign cur_key_adr = cur_key_adr_q;
    assign cur_key_val = cur_key_val_q;
    assign cur_vel_on  = cur_vel_on_q;
    assign keys_on     = keys_on_q;

endmodule
